// File: rtl/mips32_pkg.sv
// Opcode constants and helpers shared between fetch, pipeline and decode.
package mips32_pkg;

   localparam int WORD_W  = 32;
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam logic [OPC_MSB-OPC_LSB:0] OPC_HLT = 6'h3f;

   function automatic logic is_hlt(input logic [WORD_W-1:0] word);
      return word[OPC_MSB:OPC_LSB] == OPC_HLT;
   endfunction

endpackage

// File: rtl/mips32_fetch_queue_if.sv
// Fetch-stage bus: instruction memory port, decode handshake, redirect and halt status.
interface mips32_fetch_queue_if #(parameter int ADDR_W = 32);

   logic                          imem_rd_en;
   logic [ADDR_W-1:0]             imem_addr;
   logic [mips32_pkg::WORD_W-1:0] imem_rdata;
   logic                          id_valid;
   logic                          id_ready;
   logic [mips32_pkg::WORD_W-1:0] id_ir;
   logic [ADDR_W-1:0]             id_npc;
   logic                          redirect_valid;
   logic [ADDR_W-1:0]             redirect_pc;
   logic                          halt_seen;

   modport master (
      output imem_rd_en, imem_addr, id_valid, id_ir, id_npc, halt_seen,
      input  imem_rdata, id_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_rd_en, imem_addr, id_valid, id_ir, id_npc, halt_seen,
      output imem_rdata, id_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/mips32_fetch_fifo.sv
// Synchronous FIFO holding fetched {ir, npc} pairs; flush has priority over push.
module mips32_fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   // Push into a full queue is only accepted when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction fetch stage: issues word reads, queues returned words with their NPC,
// and feeds decode over valid/ready. Handles branch redirects and stops after HLT.
module mips32_fetch_queue
   import mips32_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                  clk,
   input logic                  reset,
   mips32_fetch_queue_if.master fq
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [ADDR_W-1:0]        pc;
   logic [ADDR_W-1:0]        issued_addr;
   logic                     inflight;
   logic                     halt_seen;

   logic [CW-1:0]            count;
   logic                     full;
   logic                     empty;
   logic [WORD_W+ADDR_W-1:0] head;
   logic [WORD_W+ADDR_W-1:0] entry;
   logic [CW:0]              occupancy;
   logic                     pop;
   logic                     push;
   logic                     issue;

   assign pop       = !empty && fq.id_ready;
   // Count the in-flight word as occupied so a returning word always has a slot.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign issue     = !reset && !halt_seen && !fq.redirect_valid && (occupancy < DEPTH_C);
   assign push      = inflight && !halt_seen && !fq.redirect_valid && (!full || pop);
   assign entry     = {fq.imem_rdata, issued_addr + ADDR_W'(1)};

   mips32_fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (WORD_W + ADDR_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (fq.redirect_valid),
      .wdata (entry),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign fq.imem_rd_en = issue;
   assign fq.imem_addr  = pc;
   assign fq.id_valid   = !empty;
   assign fq.id_ir      = empty ? '0 : head[WORD_W+ADDR_W-1:ADDR_W];
   assign fq.id_npc     = empty ? '0 : head[ADDR_W-1:0];
   assign fq.halt_seen  = halt_seen;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         issued_addr <= '0;
         inflight    <= 1'b0;
         halt_seen   <= 1'b0;
      end else if (fq.redirect_valid) begin
         pc        <= fq.redirect_pc;
         inflight  <= 1'b0;
         halt_seen <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc          <= pc + ADDR_W'(1);
            issued_addr <= pc;
         end
         if (push && is_hlt(fq.imem_rdata))
            halt_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for the fetch queue against a small synchronous instruction memory.
module tb_mips32_fetch_queue;
   import mips32_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mips32_fetch_queue_if #(.ADDR_W(32)) fq ();

   mips32_fetch_queue #(
      .DEPTH    (4),
      .ADDR_W   (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (fq)
   );

   logic [31:0] mem [64];

   always @(posedge clk) begin
      if (fq.imem_rd_en)
         fq.imem_rdata <= mem[fq.imem_addr[5:0]];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag, input int max);
      int n = 0;
      while (!fq.id_valid && n < max) begin
         step();
         n++;
      end
      check(tag, {63'd0, fq.id_valid}, 64'd1);
   endtask

   task automatic hold_reset();
      reset = 1'b1;
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy;
      for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | 32'(i);
      mem[0]  = 32'h2801_0005;
      mem[1]  = 32'h2802_000a;
      mem[2]  = 32'h2803_0014;
      mem[3]  = 32'h2804_0001;
      mem[10] = 32'hfc00_0000;
      fq.imem_rdata     = '0;
      fq.id_ready       = 1'b1;
      fq.redirect_valid = 1'b0;
      fq.redirect_pc    = '0;

      // 1: reset state, latency and streaming
      hold_reset();
      check("rst_rd_en",     {63'd0, fq.imem_rd_en}, 64'd0);
      check("rst_id_valid",  {63'd0, fq.id_valid},   64'd0);
      check("rst_id_ir",     {32'd0, fq.id_ir},      64'd0);
      check("rst_id_npc",    {32'd0, fq.id_npc},     64'd0);
      check("rst_halt_seen", {63'd0, fq.halt_seen},  64'd0);
      reset = 1'b0;
      #1;
      check("t1_c0_rd_en", {63'd0, fq.imem_rd_en}, 64'd1);
      check("t1_c0_addr",  {32'd0, fq.imem_addr},  64'd0);
      step();
      check("t1_c1_valid", {63'd0, fq.id_valid}, 64'd0);
      step();
      for (int k = 0; k < 4; k++) begin
         check("t1_valid", {63'd0, fq.id_valid}, 64'd1);
         check("t1_entry", {fq.id_ir, fq.id_npc}, {mem[k], 32'(k + 1)});
         step();
      end

      // 2: backpressure fills the queue, then drains in order
      fq.id_ready = 1'b0;
      hold_reset();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 5 || i == 9)
            check("t2_hold_head", {fq.id_ir, fq.id_npc}, {mem[0], 32'd1});
         step();
      end
      check("t2_full_rd_en", {63'd0, fq.imem_rd_en}, 64'd0);
      check("t2_full_valid", {63'd0, fq.id_valid},   64'd1);
      fq.id_ready = 1'b1;
      #1;
      check("t2_resume_rd_en", {63'd0, fq.imem_rd_en}, 64'd1);
      for (int k = 0; k < 8; k++) begin
         check("t2_drain", {fq.id_ir, fq.id_npc}, {mem[k], 32'(k + 1)});
         step();
      end

      // 3: redirect with 3 queued entries and one read in flight
      fq.id_ready = 1'b0;
      hold_reset();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      fq.redirect_valid = 1'b1;
      fq.redirect_pc    = 32'd8;
      #1;
      check("t3_redir_no_issue", {63'd0, fq.imem_rd_en}, 64'd0);
      step();
      fq.redirect_valid = 1'b0;
      fq.id_ready       = 1'b1;
      check("t3_flushed", {63'd0, fq.id_valid}, 64'd0);
      wait_valid("t3_wait_target", 8);
      check("t3_target", {fq.id_ir, fq.id_npc}, {mem[8], 32'd9});
      step();
      check("t3_next", {fq.id_ir, fq.id_npc}, {mem[9], 32'd10});

      // 4: HLT at mem[10] stops fetch
      step();
      check("t4_hlt_entry", {fq.id_ir, fq.id_npc}, {32'hfc00_0000, 32'd11});
      check("t4_halt_seen", {63'd0, fq.halt_seen}, 64'd1);
      step();
      check("t4_no_mem11", {63'd0, fq.id_valid}, 64'd0);
      busy = 0;
      for (int i = 0; i < 20; i++) begin
         if (fq.imem_rd_en || fq.id_valid) busy++;
         step();
      end
      check("t4_idle_cycles", 64'(busy), 64'd0);
      check("t4_halt_held", {63'd0, fq.halt_seen}, 64'd1);

      // 5: redirect clears halt
      fq.redirect_valid = 1'b1;
      fq.redirect_pc    = 32'd2;
      step();
      fq.redirect_valid = 1'b0;
      check("t5_halt_clear", {63'd0, fq.halt_seen}, 64'd0);
      check("t5_flushed",    {63'd0, fq.id_valid},  64'd0);
      wait_valid("t5_wait_target", 8);
      check("t5_target", {fq.id_ir, fq.id_npc}, {mem[2], 32'd3});
      step();
      check("t5_next", {fq.id_ir, fq.id_npc}, {mem[3], 32'd4});

      // 6: reset with a full queue
      fq.id_ready = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("t6_full_rd_en", {63'd0, fq.imem_rd_en}, 64'd0);
      check("t6_full_valid", {63'd0, fq.id_valid},   64'd1);
      reset = 1'b1;
      step();
      check("t6_rst_valid", {63'd0, fq.id_valid},   64'd0);
      check("t6_rst_rd_en", {63'd0, fq.imem_rd_en}, 64'd0);
      reset       = 1'b0;
      fq.id_ready = 1'b1;
      #1;
      check("t6_restart_rd_en", {63'd0, fq.imem_rd_en}, 64'd1);
      check("t6_restart_addr",  {32'd0, fq.imem_addr},  64'd0);
      step();
      step();
      check("t6_restart_head", {fq.id_ir, fq.id_npc}, {mem[0], 32'd1});

      // 7: pc wraps from all-ones to zero
      fq.redirect_valid = 1'b1;
      fq.redirect_pc    = 32'hffff_ffff;
      step();
      fq.redirect_valid = 1'b0;
      #1;
      check("t7_issue_top", {31'd0, fq.imem_rd_en, fq.imem_addr}, {31'd0, 1'b1, 32'hffff_ffff});
      step();
      check("t7_issue_wrap", {31'd0, fq.imem_rd_en, fq.imem_addr}, {31'd0, 1'b1, 32'h0});
      wait_valid("t7_wait_top", 8);
      check("t7_top_entry",  {fq.id_ir, fq.id_npc}, {mem[63], 32'd0});
      step();
      check("t7_wrap_entry", {fq.id_ir, fq.id_npc}, {mem[0], 32'd1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
